// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Package : music_pkg
// Brief   : Shared note definitions for the tone generator and tone detector:
//           note frequency table (C4..D#6), sentinel index and the period
//           helper that both sides use to agree on tone timing.
// Rev     : 1.0  initial release
// ============================================================================
package music_pkg;

    localparam logic [5:0] NOTE_NONE = 6'd63;
    localparam int         NUM_NOTES = 28;

    // Equal-tempered frequencies rounded to whole Hz, index 0 = C4, 27 = D#6
    localparam int NOTE_HZ [NUM_NOTES] = '{
        262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
        523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988,
        1047, 1109, 1175, 1245
    };

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_DECIDE  = 2'd3
    } det_state_t;

    // Full square-wave period in clocks; the generator toggles after N+1
    // clocks per half period, with N = clk_hz / f.
    function automatic logic [19:0] expected_period(input int idx, input int clk_hz);
        return 20'(2 * (clk_hz / NOTE_HZ[idx] + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_sync.sv
`default_nettype none
// ============================================================================
// Module  : sound_sync
// Brief   : Two-flop synchroniser for the asynchronous sound input followed
//           by a registered rising-edge pulse (three clocks of lag overall).
// Rev     : 1.0  initial release
// ============================================================================
module sound_sync (
    input  logic clk,
    input  logic rst,
    input  logic sound,
    output logic rise
);

    // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect
    logic [2:0] sync_q;

    // Shift the input through the synchroniser and flag 0->1 transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sound};
            rise   <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule
`default_nettype wire

// File: rtl/music_tone_detect.sv
`default_nettype none
// ============================================================================
// Module  : music_tone_detect
// Brief   : Measures the period of a square-wave tone and decodes it back to
//           the note index (0..27) that the tone generator would have used.
//           Reports NOTE_NONE (63) when the tone is absent or unrecognised.
// Rev     : 1.0  initial release
// ============================================================================
module music_tone_detect
    import music_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_CYC = 800_000,
    parameter int STABLE_CNT  = 2,
    parameter int TOL_SHIFT   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sound,
    output logic [5:0] note,
    output logic       note_valid,
    output logic       note_change
);

    localparam int                STAB_W    = $clog2(STABLE_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CNT);
    localparam logic [19:0]       TIMEOUT_V = 20'(TIMEOUT_CYC);
    localparam logic [4:0]        LAST_IDX  = 5'(NUM_NOTES - 1);

    logic rise;

    sound_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .sound (sound),
        .rise  (rise)
    );

    // Constant ROM of expected periods and match windows
    logic [19:0] rom_period [NUM_NOTES];
    logic [19:0] rom_tol    [NUM_NOTES];

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_rom
        localparam logic [19:0] P = expected_period(i, CLK_HZ);
        assign rom_period[i] = P;
        assign rom_tol[i]    = P >> TOL_SHIFT;
    end

    det_state_t        state, state_n;
    logic [19:0]       cnt;
    logic [19:0]       period, period_n;
    logic [4:0]        idx, idx_n;
    logic [5:0]        res, res_n;
    logic [5:0]        cand, cand_n;
    logic [STAB_W-1:0] stab, stab_n;
    logic [5:0]        note_n;
    logic              valid_n;
    logic              change_n;

    logic [19:0] ref_p;
    logic [19:0] diff;
    logic        hit;
    logic        timeout;

    // Free-running edge-to-edge counter, parked at the timeout value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != TIMEOUT_V) begin
            cnt <= cnt + 20'd1;
        end
    end

    // Table comparison for the entry currently under test
    always_comb begin
        ref_p   = rom_period[idx];
        diff    = (period >= ref_p) ? (period - ref_p) : (ref_p - period);
        hit     = (diff <= rom_tol[idx]);
        timeout = (cnt == TIMEOUT_V) && !rise;
    end

    // Next-state and output decode
    always_comb begin
        state_n  = state;
        period_n = period;
        idx_n    = idx;
        res_n    = res;
        cand_n   = cand;
        stab_n   = stab;
        note_n   = note;
        valid_n  = note_valid;
        change_n = 1'b0;

        case (state)
            ST_ARM: begin
                if (rise) begin
                    state_n = ST_MEASURE;
                end else if (timeout) begin
                    cand_n = NOTE_NONE;
                    stab_n = '0;
                    if (note != NOTE_NONE) begin
                        note_n   = NOTE_NONE;
                        valid_n  = 1'b0;
                        change_n = 1'b1;
                    end
                end
            end

            ST_MEASURE: begin
                if (rise) begin
                    // Counter holds edge distance minus one at this point
                    period_n = cnt + 20'd1;
                    idx_n    = '0;
                    state_n  = ST_SEARCH;
                end else if (timeout) begin
                    state_n = ST_ARM;
                    cand_n  = NOTE_NONE;
                    stab_n  = '0;
                    if (note != NOTE_NONE) begin
                        note_n   = NOTE_NONE;
                        valid_n  = 1'b0;
                        change_n = 1'b1;
                    end
                end
            end

            ST_SEARCH: begin
                if (hit) begin
                    res_n   = {1'b0, idx};
                    state_n = ST_DECIDE;
                end else if (idx == LAST_IDX) begin
                    res_n   = NOTE_NONE;
                    state_n = ST_DECIDE;
                end else begin
                    idx_n = idx + 5'd1;
                end
            end

            ST_DECIDE: begin
                if (res == cand) begin
                    stab_n = (stab == STAB_MAX) ? stab : stab + STAB_W'(1);
                end else begin
                    stab_n = STAB_W'(1);
                end
                cand_n = res;
                if ((stab_n >= STAB_MAX) && (res != note)) begin
                    note_n   = res;
                    valid_n  = (res != NOTE_NONE);
                    change_n = 1'b1;
                end
                state_n = ST_MEASURE;
            end

            default: begin
                state_n = ST_ARM;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ARM;
            period      <= '0;
            idx         <= '0;
            res         <= NOTE_NONE;
            cand        <= NOTE_NONE;
            stab        <= '0;
            note        <= NOTE_NONE;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
        end else begin
            state       <= state_n;
            period      <= period_n;
            idx         <= idx_n;
            res         <= res_n;
            cand        <= cand_n;
            stab        <= stab_n;
            note        <= note_n;
            note_valid  <= valid_n;
            note_change <= change_n;
        end
    end

endmodule
`default_nettype wire
